// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns 16-bit host frames into single-cycle register strobes.
// Frame: bit15 = R/W (1 = read), bits[14:8] = address, bits[7:0] = write data.
// All SPI pins are oversampled in the clk domain; sclk must be at most clk/16.
module spi_reg_bridge #(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RD_LATENCY  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              frame_err
);

  // Rise counts at which the command byte and the whole frame are complete (0-based).
  localparam logic [4:0] CmdLast     = 5'(ADDR_W);
  localparam logic [4:0] FrameLast   = 5'(ADDR_W + DATA_W);
  localparam logic [4:0] FrameLen    = FrameLast + 5'd1;
  localparam logic [4:0] CntSat      = FrameLen + 5'd1;
  localparam logic [2:0] FlushCycles = 3'(SYNC_STAGES + 1);

  typedef enum logic [2:0] {
    StIdle, StCmd, StRdStb, StRdWait, StRdData, StWrData, StWrStb, StDone
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_dly, cs_dly;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall, cs_fall_ok;
  logic [2:0]             flush_q;
  logic                   armed_q;
  logic [4:0]             bit_cnt_q;
  logic [DATA_W-2:0]      shift_q;
  logic [DATA_W-1:0]      tx_q;
  logic                   miso_q;
  logic [1:0]             lat_q;
  logic                   cmd_done, wr_done, rd_done, load_tx;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly;
  assign sclk_fall = ~sclk_s & sclk_dly;
  assign cs_rise   = cs_s & ~cs_dly;
  assign cs_fall   = ~cs_s & cs_dly;
  // A cs_n already low when reset drops must not look like a fresh frame start.
  assign cs_fall_ok = cs_fall & armed_q;

  // Last command / data bit sampled without a competing cs_n edge.
  assign cmd_done = (state_q == StCmd) & sclk_rise & (bit_cnt_q == CmdLast) &
                    ~cs_fall_ok & ~cs_rise;
  assign wr_done  = (state_q == StWrData) & sclk_rise & (bit_cnt_q == FrameLast) &
                    ~cs_fall_ok & ~cs_rise;
  assign rd_done  = (state_q == StRdData) & sclk_rise & (bit_cnt_q == FrameLast) &
                    ~cs_fall_ok & ~cs_rise;
  assign load_tx  = ((state_q == StRdStb) && (RD_LATENCY == 0)) ||
                    ((state_q == StRdWait) && (lat_q == 2'(RD_LATENCY)));

  // Input synchronizers plus one delay flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_dly  <= 1'b0;
      cs_dly    <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_dly  <= sclk_s;
      cs_dly    <= cs_s;
    end
  end

  // Arm frame starts only once cs_n has been seen high with a flushed synchronizer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_q <= '0;
      armed_q <= 1'b0;
    end else begin
      if (flush_q != FlushCycles) flush_q <= flush_q + 3'd1;
      if ((flush_q == FlushCycles) && cs_s) armed_q <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next state; cs_n edges override everything.
  always_comb begin
    state_d = state_q;
    if (cs_fall_ok) begin
      state_d = StCmd;
    end else if (cs_rise) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StCmd:    if (cmd_done) state_d = shift_q[ADDR_W-1] ? StRdStb : StWrData;
        StRdStb:  state_d = (RD_LATENCY == 0) ? StRdData : StRdWait;
        StRdWait: if (load_tx) state_d = StRdData;
        StRdData: if (rd_done) state_d = StDone;
        StWrData: if (wr_done) state_d = StWrStb;
        StWrStb:  state_d = StDone;
        default:  ;
      endcase
    end
  end

  // FSM outputs: strobes are decoded straight from state so reset clears them at once.
  always_comb begin
    reg_rd_en = (state_q == StRdStb);
    reg_wr_en = (state_q == StWrStb);
    spi_miso  = (state_q == StRdData) & miso_q;
  end

  // Bit counter, shift registers, latched register-side outputs and status flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      lat_q       <= '0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      spi_miso_oe <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      spi_miso_oe <= ~cs_s;
      frame_err   <= cs_rise && (state_q != StIdle) &&
                     (bit_cnt_q != 5'd0) && (bit_cnt_q != FrameLen);

      if (cs_fall_ok) begin
        bit_cnt_q <= '0;
        shift_q   <= '0;
      end else if (sclk_rise && (state_q != StIdle)) begin
        if (bit_cnt_q != CntSat) bit_cnt_q <= bit_cnt_q + 5'd1;
        shift_q <= {shift_q[DATA_W-3:0], mosi_s};
      end

      if (cmd_done) reg_addr  <= {shift_q[ADDR_W-2:0], mosi_s};
      if (wr_done)  reg_wdata <= {shift_q, mosi_s};

      if (state_q == StRdStb)       lat_q <= 2'd1;
      else if (state_q == StRdWait) lat_q <= lat_q + 2'd1;

      if (load_tx) tx_q <= reg_rdata;
      else if ((state_q == StRdData) && sclk_fall) tx_q <= {tx_q[DATA_W-2:0], 1'b0};

      // MISO changes on sclk fall so the host sees a stable bit at its next rise.
      if (state_q != StRdData) miso_q <= 1'b0;
      else if (sclk_fall)      miso_q <= tx_q[DATA_W-1];
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: a host model drives SPI frames, a register block model answers
// reads, and a monitor matches every strobe / frame_err against a queue of expected events.
module tb_spi_reg_bridge;

  localparam int unsigned AW  = 7;
  localparam int unsigned DW  = 8;
  localparam int unsigned RDL = 1;

  localparam logic [1:0] KWr  = 2'd0;
  localparam logic [1:0] KRd  = 2'd1;
  localparam logic [1:0] KErr = 2'd2;

  typedef struct packed {
    logic [1:0]    kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          spi_sclk, spi_cs_n, spi_mosi;
  logic          spi_miso, spi_miso_oe;
  logic [AW-1:0] reg_addr;
  logic          reg_wr_en, reg_rd_en, frame_err;
  logic [DW-1:0] reg_wdata, reg_rdata;

  ev_t exp_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  logic [DW-1:0] mem [128];
  bit            mem_seen [128];
  logic [DW-1:0] mdl [128];
  bit            mdl_seen [128];
  logic [DW-1:0] last_wdata = '0;

  spi_reg_bridge #(
    .ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(2), .RD_LATENCY(RDL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .reg_addr   (reg_addr),
    .reg_wr_en  (reg_wr_en),
    .reg_rd_en  (reg_rd_en),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Power-on contents of registers never written.
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return ({1'b0, a} * 8'd37) ^ 8'h5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Register block: one-cycle read latency, garbage on reg_rdata otherwise.
  always @(posedge clk) begin
    if (reg_wr_en) begin
      mem[reg_addr]      <= reg_wdata;
      mem_seen[reg_addr] <= 1'b1;
    end
    reg_rdata <= reg_rd_en ? (mem_seen[reg_addr] ? mem[reg_addr] : init_val(reg_addr))
                           : 8'($urandom);
  end

  task automatic pop_check(input logic [1:0] kind, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event: got kind %0d addr 0x%0h, required no event", kind, a);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      if (kind != KErr) check("event_addr", 32'(a), 32'(e.addr));
      if (kind == KWr)  check("event_wdata", 32'(d), 32'(e.data));
    end
  endtask

  // Monitor: samples on the falling clk edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (reg_wr_en && reg_rd_en) check("strobe_exclusive", 32'd1, 32'd0);
      if (reg_wr_en) pop_check(KWr, reg_addr, reg_wdata);
      if (reg_rd_en) pop_check(KRd, reg_addr, '0);
      if (frame_err) pop_check(KErr, '0, '0);
    end
  end

  task automatic half_bit();
    repeat (8) @(posedge clk);
    #2;
  endtask

  // Expected events of a frame of n bits, straight from the frame rules.
  task automatic model_frame(input logic [15:0] word, input int n,
                             output bit is_rd, output logic [DW-1:0] rd_data);
    logic [AW-1:0] a;
    a       = word[14:8];
    is_rd   = word[15];
    rd_data = mdl_seen[a] ? mdl[a] : init_val(a);
    if (is_rd && n >= 8) exp_q.push_back(ev_t'{kind: KRd, addr: a, data: '0});
    if (!is_rd && n >= 16) begin
      exp_q.push_back(ev_t'{kind: KWr, addr: a, data: word[7:0]});
      mdl[a]      = word[7:0];
      mdl_seen[a] = 1'b1;
      last_wdata  = word[7:0];
    end
    if (n != 0 && n != 16) exp_q.push_back(ev_t'{kind: KErr, addr: '0, data: '0});
  endtask

  // Host shifts n bits (extras beyond 16 are random) and samples MISO at each rise.
  task automatic shift_bits(input logic [15:0] word, input int n, input bit is_rd,
                            input logic [DW-1:0] rd_data);
    logic exp_bit;
    for (int i = 0; i < n; i++) begin
      spi_mosi = (i < 16) ? word[15-i] : 1'($urandom);
      half_bit();
      exp_bit = (is_rd && i >= 8 && i < 16) ? rd_data[15-i] : 1'b0;
      check($sformatf("miso_bit%0d", i), 32'(spi_miso), 32'(exp_bit));
      if (i == 0) check("miso_oe_active", 32'(spi_miso_oe), 32'd1);
      spi_sclk = 1'b1;
      half_bit();
      spi_sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [15:0] word, input int n);
    bit            is_rd;
    logic [DW-1:0] rd_data;
    model_frame(word, n, is_rd, rd_data);
    spi_cs_n = 1'b0;
    half_bit();
    shift_bits(word, n, is_rd, rd_data);
    half_bit();
    spi_cs_n = 1'b1;
    repeat (24) @(posedge clk);
    #2;
    check("miso_oe_idle", 32'(spi_miso_oe), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, 32'({spi_miso, spi_miso_oe, reg_wr_en, reg_rd_en, frame_err, reg_addr,
                     reg_wdata}), 32'd0);
  endtask

  initial begin
    int            r, n;
    logic [15:0]   w;
    logic [DW-1:0] rd1;
    reset    = 1'b1;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;

    // Reset with sclk toggling, then idle sclk activity with cs_n high.
    for (int i = 0; i < 6; i++) begin
      #40 spi_sclk = ~spi_sclk;
      spi_mosi = ~spi_mosi;
    end
    check_all_zero("reset_outputs");
    #3 reset = 1'b0;
    for (int i = 0; i < 8; i++) #40 spi_sclk = ~spi_sclk;
    repeat (10) @(posedge clk);
    #2;
    check_all_zero("post_reset_idle");

    // Directed frames.
    run_frame(16'h01AA, 16);
    run_frame(16'h8100, 16);
    run_frame(16'h0155, 16);
    run_frame(16'h8100, 16);
    run_frame(16'h02F0, 12);
    check("wdata_hold_after_abort", 32'(reg_wdata), 32'(last_wdata));
    run_frame(16'h0333, 20);
    run_frame(16'h0000, 0);

    // Reset after bit 10 of a read: the read strobe has already fired.
    rd1 = mdl_seen[1] ? mdl[1] : init_val(7'd1);
    exp_q.push_back(ev_t'{kind: KRd, addr: 7'd1, data: '0});
    spi_cs_n = 1'b0;
    half_bit();
    shift_bits(16'h8100, 10, 1'b1, rd1);
    #3 reset = 1'b1;
    #1 check_all_zero("midframe_reset_outputs");
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 8; i++) #40 spi_sclk = ~spi_sclk;
    spi_cs_n = 1'b1;
    repeat (24) @(posedge clk);
    #2;
    check("queue_after_reset", 32'(exp_q.size()), 32'd0);
    run_frame(16'h0411, 16);
    run_frame(16'h8400, 16);

    // Randomized frames: mostly complete, some empty, aborted or overrun.
    for (int k = 0; k < 16; k++) begin
      w = 16'($urandom);
      r = int'($urandom_range(0, 9));
      if (r < 6)       n = 16;
      else if (r == 6) n = 0;
      else if (r == 7) n = int'($urandom_range(1, 15));
      else             n = int'($urandom_range(17, 20));
      run_frame(w, n);
    end

    repeat (20) @(posedge clk);
    #2;
    check("queue_empty_at_end", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- SPI slave (mode 0, MSB first) that turns 16-bit host frames into single-cycle register strobes.
- Strobes are rd_en/wr_en/data_in style, consumed by front-end register peripherals such as the LED control block.
- Acts as the initiator side of the register interface: decodes the address, issues write or read strobes, and returns read data on MISO within the same frame.
- Sits between the board MCU SPI pins and the register peripherals, all in the clk domain.

Parameters:
- ADDR_W, 7: register address width; frame bits [14:8].
- DATA_W, 8: register data width; frame bits [7:0].
- SYNC_STAGES, 2: flops on spi_sclk, spi_cs_n and spi_mosi before use; legal range 2-3.
- RD_LATENCY, 1: clk cycles from reg_rd_en to valid reg_rdata; legal range 0-2.

Ports:
- clk, input, 1: system clock, the only clock.
- reset, input, 1: asynchronous, active-high reset.
- spi_sclk, input, 1: SPI clock, asynchronous to clk, at most clk/16.
- spi_cs_n, input, 1: SPI chip select, active low.
- spi_mosi, input, 1: serial data from host.
- spi_miso, output, 1: serial data to host.
- spi_miso_oe, output, 1: MISO output enable, high while the frame is selected.
- reg_addr, output, ADDR_W: decoded register address.
- reg_wr_en, output, 1: one-cycle write strobe.
- reg_rd_en, output, 1: one-cycle read strobe.
- reg_wdata, output, DATA_W: write data.
- reg_rdata, input, DATA_W: read data returned by the register block.
- frame_err, output, 1: one-cycle pulse when a frame has the wrong bit count.

Behaviour:
- Reset:
  - Asynchronous on reset high; all outputs go to 0 immediately, state goes to IDLE, bit counter and shift register are cleared.
  - Synchronizer flops reset to sclk=0, cs_n=1, mosi=0.
- Input sync and edge detect:
  - spi_sclk, spi_cs_n and spi_mosi pass through SYNC_STAGES flops.
  - Edges are detected by comparing the last synchronized stage with one extra delay flop.
  - A synchronized sclk rise samples mosi; a synchronized sclk fall updates miso.
- Frame format:
  - bit15 = R/W (1 = read), bits[14:8] = address, bits[7:0] = write data (don't-care for reads).
- Bit counter:
  - 5 bits, counts synchronized sclk rises, cleared on synchronized cs_n fall.
  - Saturates at 17, which means overrun.
- States:
  - IDLE -> CMD on cs_n fall.
  - CMD: shift in 8 bits. After the 8th rise, latch reg_addr and the R/W bit. Write goes to WDATA. Read pulses reg_rd_en for one clk on the cycle after the 8th rise detect, then goes to RWAIT.
  - RWAIT: wait RD_LATENCY cycles, load reg_rdata into the tx shift register, go to RDATA.
  - RDATA: on each sclk fall drive the next tx bit MSB first. The first bit (rdata[7]) is driven on the 8th sclk fall. After the 16th rise go to DONE.
  - WDATA: shift 8 bits. After the 16th rise, update reg_wdata and pulse reg_wr_en for one clk on the following cycle. reg_addr is already stable. Go to DONE.
  - DONE: ignore further edges; extra rises only advance the saturating counter.
  - Any state -> IDLE on cs_n rise.
- Outputs:
  - spi_miso_oe = synchronized cs_n low, registered.
  - spi_miso = 0 except during RDATA.
  - reg_addr and reg_wdata hold their values until the next strobe that updates them; they never change while a strobe is high.
  - reg_wr_en and reg_rd_en are mutually exclusive, and each fires at most once per frame.
- frame_err:
  - Pulses one clk on cs_n rise when bit_cnt is neither 0 nor 16.
  - Abort before 16 bits: no write strobe. The read strobe stays issued if it already fired.
  - Overrun (at least 17 bits): the strobe from the 16th bit stands.
  - A cs_n toggle with 0 bits gives no error and no strobe.
- cs_n fall while not in IDLE (cs_n rise and fall seen on the same sync cycle): treated as a new frame start. Counter is cleared and no strobe is issued for the old frame.
- Reset mid-frame: everything clears; after release the block waits in IDLE for a fresh cs_n fall. A cs_n that is already low does not start a frame.

Test Plan:
- Reset pulse with sclk toggling -> all outputs 0; after release, no strobes until a cs_n fall.
- Write frame 0x01AA at clk/16 -> exactly one reg_wr_en pulse, reg_addr=0x01, reg_wdata=0xAA, reg_rd_en never high, frame_err 0.
- Read frame 0x8100, bench model returns 0x55 after RD_LATENCY -> one reg_rd_en with reg_addr=0x01; host samples MISO bits 8-15 = 0,1,0,1,0,1,0,1; MISO=0 during bits 0-7.
- Write 0x02F0 aborted (cs_n high) after 12 bits -> no reg_wr_en, one frame_err pulse, reg_wdata unchanged.
- 20-bit write frame 0x0333 plus 4 extra bits -> one reg_wr_en with addr 0x03 and data 0x33 after bit 16, frame_err pulse at cs_n rise.
- Reset asserted after bit 10 of a read frame -> outputs 0 immediately, no further strobes; the next full write 0x0411 completes normally.
